// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and helpers for the sync circular FIFO
package sync_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Address bits for a power-of-two depth; pointers add one wrap bit on top.
    function automatic int fifo_addr_bits(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// rtl/fifo_mem_2p.sv - register array, one synchronous write port, one asynchronous read port
module fifo_mem_2p #(
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_FIFO_BLOCKS = 1024,
    parameter int ADDR_BITS       = $clog2(NUM_FIFO_BLOCKS)
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_BITS-1:0]  wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_BITS-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_FIFO_BLOCKS];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = r_mem[rd_addr_i];

endmodule

// File: rtl/sync_circular_fifo_flags.sv
// rtl/sync_circular_fifo_flags.sv - single-clock circular FIFO with STD/FWFT read, thresholds, sticky errors, flush
module sync_circular_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH          = 64,
    parameter int NUM_FIFO_BLOCKS     = 1024,
    parameter int POINTER_NUM_BITS    = fifo_addr_bits(NUM_FIFO_BLOCKS),
    parameter int FWFT                = FIFO_MODE_STD,
    parameter int ALMOST_FULL_THRESH  = NUM_FIFO_BLOCKS - 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        clr_flags_i,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        wr_en_i,
    output logic                        full_o,
    output logic                        almost_full_o,
    input  logic                        rd_en_i,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    output logic                        empty_o,
    output logic                        almost_empty_o,
    output logic [POINTER_NUM_BITS:0]   count_o,
    output logic                        overflow_o,
    output logic                        underflow_o
);

    localparam int PW = POINTER_NUM_BITS + 1;
    localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_THRESH);

    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);

    // A read frees a slot in the same edge, so a full FIFO can still take a write.
    assign w_rd_acc  = !flush_i && rd_en_i && !w_empty;
    assign w_wr_acc  = !flush_i && wr_en_i && (!w_full || w_rd_acc);
    assign w_ovf_set = !flush_i && wr_en_i && w_full && !w_rd_acc;
    assign w_unf_set = !flush_i && rd_en_i && w_empty;

    fifo_mem_2p #(
        .DATA_WIDTH      (DATA_WIDTH),
        .NUM_FIFO_BLOCKS (NUM_FIFO_BLOCKS),
        .ADDR_BITS       (POINTER_NUM_BITS)
    ) u_mem (
        .clk_i     (clk_i),
        .wr_en_i   (w_wr_acc),
        .wr_addr_i (r_wr_ptr[PW-2:0]),
        .wr_data_i (data_i),
        .rd_addr_i (r_rd_ptr[PW-2:0]),
        .rd_data_o (w_rd_data)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + PW'(w_wr_acc) - PW'(w_rd_acc);
        end
    end

    // A new error in the clearing cycle wins over the clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_flags_i) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_flags_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign data_o  = w_rd_data;
            assign valid_o = !w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_valid;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (flush_i) begin
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data <= w_rd_data;
                    end
                end
            end

            assign data_o  = r_data;
            assign valid_o = r_valid;
        end
    endgenerate

    assign full_o         = w_full;
    assign empty_o        = w_empty;
    assign count_o        = r_count;
    assign almost_full_o  = (r_count >= AF_LVL);
    assign almost_empty_o = (r_count <= AE_LVL);
    assign overflow_o     = r_overflow;
    assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_sync_circular_fifo_flags.sv
// tb/tb_sync_circular_fifo_flags.sv - directed self-checking bench, STD and FWFT instances against a queue model
module tb_sync_circular_fifo_flags;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          clr = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [DW-1:0] din = '0;

    logic          s_full, s_af, s_valid, s_empty, s_ae, s_ovf, s_unf;
    logic [DW-1:0] s_data;
    logic [3:0]    s_count;
    logic          f_full, f_af, f_valid, f_empty, f_ae, f_ovf, f_unf;
    logic [DW-1:0] f_data;
    logic [3:0]    f_count;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    sync_circular_fifo_flags #(
        .DATA_WIDTH(DW), .NUM_FIFO_BLOCKS(DEPTH), .FWFT(0)
    ) u_std (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .clr_flags_i(clr),
        .data_i(din), .wr_en_i(wr), .full_o(s_full), .almost_full_o(s_af),
        .rd_en_i(rd), .data_o(s_data), .valid_o(s_valid), .empty_o(s_empty),
        .almost_empty_o(s_ae), .count_o(s_count), .overflow_o(s_ovf),
        .underflow_o(s_unf)
    );

    sync_circular_fifo_flags #(
        .DATA_WIDTH(DW), .NUM_FIFO_BLOCKS(DEPTH), .FWFT(1)
    ) u_fwft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .clr_flags_i(clr),
        .data_i(din), .wr_en_i(wr), .full_o(f_full), .almost_full_o(f_af),
        .rd_en_i(rd), .data_o(f_data), .valid_o(f_valid), .empty_o(f_empty),
        .almost_empty_o(f_ae), .count_o(f_count), .overflow_o(f_ovf),
        .underflow_o(f_unf)
    );

    // Behavioural model: contents as a queue, outputs derived from its size.
    logic [DW-1:0] q[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;
    bit            m_svalid = 1'b0;
    logic [DW-1:0] m_sdata = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_svalid = 1'b0;
            m_sdata = '0;
        end else if (flush) begin
            q.delete();
            m_svalid = 1'b0;
        end else begin
            int n;
            bit rd_ok, wr_ok;
            n = q.size();
            rd_ok = rd && (n > 0);
            wr_ok = wr && ((n < DEPTH) || rd_ok);
            if (rd_ok) m_sdata = q.pop_front();
            m_svalid = rd_ok;
            if (wr_ok) q.push_back(din);
            m_ovf = (wr && !wr_ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = (rd && !rd_ok) ? 1'b1 : (clr ? 1'b0 : m_unf);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int n;
            n = q.size();
            chk("s_count", int'(s_count), n);
            chk("s_empty", int'(s_empty), int'(n == 0));
            chk("s_full",  int'(s_full),  int'(n == DEPTH));
            chk("s_af",    int'(s_af),    int'(n >= AF));
            chk("s_ae",    int'(s_ae),    int'(n <= AE));
            chk("s_ovf",   int'(s_ovf),   int'(m_ovf));
            chk("s_unf",   int'(s_unf),   int'(m_unf));
            chk("s_valid", int'(s_valid), int'(m_svalid));
            chk("s_data",  int'(s_data),  int'(m_sdata));
            chk("f_count", int'(f_count), n);
            chk("f_empty", int'(f_empty), int'(n == 0));
            chk("f_full",  int'(f_full),  int'(n == DEPTH));
            chk("f_af",    int'(f_af),    int'(n >= AF));
            chk("f_ae",    int'(f_ae),    int'(n <= AE));
            chk("f_ovf",   int'(f_ovf),   int'(m_ovf));
            chk("f_unf",   int'(f_unf),   int'(m_unf));
            chk("f_valid", int'(f_valid), int'(n > 0));
            if (n > 0) chk("f_data", int'(f_data), int'(q[0]));
        end
    end

    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic f = 1'b0, input logic c = 1'b0);
        wr = w; din = d; rd = r; flush = f; clr = c;
        @(posedge clk);
        #2;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #2;
        chk_en = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_empty", int'(s_empty), 1);
        chk("rst_ae",    int'(s_ae), 1);
        chk("rst_count", int'(s_count), 0);
        chk("rst_full",  int'(s_full), 0);
        chk("rst_ovf",   int'(s_ovf), 0);
        chk("rst_unf",   int'(s_unf), 0);
        chk("rst_valid", int'(s_valid), 0);
        chk("rst_fvalid", int'(f_valid), 0);
        cyc(0, 0, 0);

        for (int i = 1; i <= 8; i++) cyc(1, DW'(8'h11 * i), 0);
        cyc(1, 8'h99, 0);
        chk("fill_full",  int'(s_full), 1);
        chk("fill_count", int'(s_count), 8);
        chk("fill_ovf",   int'(s_ovf), 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 1);
            chk("drain_data",  int'(s_data), int'(8'h11 * i));
            chk("drain_valid", int'(s_valid), 1);
        end
        cyc(0, 0, 0);
        chk("drain_count", int'(s_count), 0);
        chk("drain_empty", int'(s_empty), 1);
        cyc(0, 0, 0, 0, 1);
        chk("clr_ovf", int'(s_ovf), 0);

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 6; j++) cyc(1, DW'(16 * (k + 1) + j), 0);
            for (int j = 0; j < 6; j++) begin
                cyc(0, 0, 1);
                chk("wrap_data", int'(s_data), 16 * (k + 1) + j);
            end
        end
        chk("wrap_count", int'(s_count), 0);
        chk("wrap_ovf",   int'(s_ovf), 0);
        chk("wrap_unf",   int'(s_unf), 0);

        for (int i = 0; i < 8; i++) cyc(1, DW'(8'hC0 + i), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, DW'(8'hD0 + i), 1);
            chk("rw_count", int'(s_count), 8);
            chk("rw_full",  int'(s_full), 1);
            chk("rw_ovf",   int'(s_ovf), 0);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1);
            chk("rw_data", int'(s_data), (i < 4) ? (8'hC4 + i) : (8'hD0 + i - 4));
        end

        cyc(1, 8'hA5, 0);
        chk("fwft_valid", int'(f_valid), 1);
        chk("fwft_data",  int'(f_data), 8'hA5);
        chk("fwft_std_valid", int'(s_valid), 0);
        cyc(0, 0, 1);
        chk("fwft_pop_empty", int'(f_empty), 1);
        cyc(0, 0, 1);
        chk("unf_set", int'(f_unf), 1);
        cyc(0, 0, 0, 0, 1);
        chk("unf_clr", int'(f_unf), 0);
        cyc(0, 0, 1, 0, 1);
        chk("unf_clr_race", int'(f_unf), 1);
        cyc(1, 8'h3C, 1, 0, 1);
        chk("wr_rd_empty_count", int'(f_count), 1);
        chk("wr_rd_empty_unf",   int'(f_unf), 1);
        cyc(0, 0, 1, 0, 1);
        chk("wr_rd_empty_data", int'(s_data), 8'h3C);

        for (int i = 0; i < 5; i++) cyc(1, DW'(i + 1), 0);
        cyc(1, 8'hEE, 1, 1);
        chk("flush_count", int'(s_count), 0);
        chk("flush_empty", int'(s_empty), 1);
        chk("flush_valid", int'(s_valid), 0);
        chk("flush_ovf",   int'(s_ovf), 0);
        chk("flush_data_kept", int'(s_data), 8'h3C);
        cyc(1, 8'h5A, 0);
        cyc(0, 0, 1);
        chk("post_flush_data", int'(s_data), 8'h5A);

        cyc(1, 8'h01, 0);
        cyc(1, 8'h02, 0);
        wr = 1'b1; din = 8'h03; rd = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(s_count), 0);
        chk("async_rst_data",  int'(s_data), 0);
        @(posedge clk);
        #2;
        wr = 1'b0; rd = 1'b0;
        rst = 1'b0;
        cyc(0, 0, 0);
        chk("post_rst_empty", int'(f_empty), 1);
        cyc(0, 0, 0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
